datamem_ctrl: RTL and testbench

//  Parametrised data memory for the MIPS MEM stage: byte/half/word loads and stores,

---
 rtl/mips_mem_pkg.sv | 21 ++
 rtl/mem_lane_align.sv | 65 ++++++
 rtl/datamem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_datamem_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared size codes, FSM states and address defaults for the MEM-stage data memory
//
// Purpose : common definitions imported by datamem_ctrl and mem_lane_align.
// Contents: SZ_* access size codes, state_e controller states, DEFAULT_BASE_ADDR.

package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0010_0000;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian byte-lane merge for stores and lane select/extend for loads
//
// Purpose : purely combinational lane steering between a 32-bit memory word and
//           right-justified store/load data.
// Ports   : size_i      access size code (SZ_BYTE/SZ_HALF/SZ_WORD)
//           unsigned_i  1 = zero-extend loads, 0 = sign-extend (ignored for words)
//           offset_i    byte offset within the word (addr[1:0])
//           old_word_i  current contents of the addressed word
//           wdata_i     right-justified store data
//           merged_o    word to write back for a store (untouched lanes preserved)
//           load_o      selected and extended load result

module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    // Big-endian: offset 0 is the most significant lane, so the shift is (3-offset)*8
    // for bytes and (1-offset[1])*16 for halves; ~offset gives exactly that.
    logic [4:0] byte_sh;
    logic [4:0] half_sh;

    assign byte_sh = {~offset_i, 3'b000};
    assign half_sh = {~offset_i[1], 4'b0000};

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        merged_o = old_word_i;
        load_o   = '0;
        lane_b   = '0;
        lane_h   = '0;
        case (size_i)
            SZ_BYTE: begin
                merged_o = (old_word_i & ~(32'h0000_00FF << byte_sh))
                         | ({24'h0, wdata_i[7:0]} << byte_sh);
                lane_b   = 8'(old_word_i >> byte_sh);
                load_o   = unsigned_i ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                merged_o = (old_word_i & ~(32'h0000_FFFF << half_sh))
                         | ({16'h0, wdata_i[15:0]} << half_sh);
                lane_h   = 16'(old_word_i >> half_sh);
                load_o   = unsigned_i ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            end
            SZ_WORD: begin
                merged_o = wdata_i;
                load_o   = old_word_i;
            end
            default: begin
                merged_o = old_word_i;
                load_o   = '0;
            end
        endcase
    end

endmodule

// File: rtl/datamem_ctrl.sv
// rtl/datamem_ctrl.sv - MEM-stage data memory with sized loads/stores, decode, faults and wait states
//
// Purpose : valid/ready data memory; IDLE -> WAIT -> RESP controller, address decode,
//           fault detection and the storage array. Lane steering lives in mem_lane_align.
// Ports   : clk, rst_n                 clock, synchronous active-low reset
//           req_valid/req_ready        request handshake
//           req_we, req_size,
//           req_unsigned, req_addr,
//           req_wdata                  request fields, sampled on the accept edge
//           rsp_valid                  one-cycle completion pulse
//           rsp_rdata, rsp_fault       load result / fault flag, valid with rsp_valid
//           busy                       request in flight

module datamem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_STATES = 0,
    parameter              INIT_FILE   = "inputmem.hex"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        busy
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  LAST_WAIT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    logic [31:0] mem_q [DEPTH_WORDS];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        commit;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_fault_q;

    logic        accept;
    assign req_ready = (state_q == ST_IDLE) & rst_n;
    assign accept    = req_valid & req_ready;
    assign busy      = (state_q != ST_IDLE);

    // With no wait states the access commits on the accept edge itself, so the
    // live request fields are used in IDLE and the latched copy everywhere else.
    logic        cur_we;
    logic [1:0]  cur_size;
    logic        cur_uns;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;

    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we    = req_we;
            cur_size  = req_size;
            cur_uns   = req_unsigned;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_we    = we_q;
            cur_size  = size_q;
            cur_uns   = uns_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    // Address decode and fault detection.
    logic [31:0]   off;
    logic          out_of_range;
    logic          misaligned;
    logic          fault;
    logic [AW-1:0] idx;

    assign off          = cur_addr - BASE_ADDR;
    assign out_of_range = (cur_addr < BASE_ADDR) | (off >= SPAN);
    assign misaligned   = ((cur_size == SZ_HALF) & cur_addr[0])
                        | ((cur_size == SZ_WORD) & (cur_addr[1:0] != 2'b00));
    assign fault        = out_of_range | misaligned | (cur_size == SZ_ILL);
    assign idx          = off[AW+1:2];

    logic [31:0] rd_word;
    logic [31:0] merged;
    logic [31:0] load_data;

    assign rd_word = mem_q[idx];

    mem_lane_align u_align (
        .size_i     (cur_size),
        .unsigned_i (cur_uns),
        .offset_i   (cur_addr[1:0]),
        .old_word_i (rd_word),
        .wdata_i    (cur_wdata),
        .merged_o   (merged),
        .load_o     (load_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAST_WAIT) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= commit;
            rsp_rdata_q <= (commit & ~cur_we & ~fault) ? load_data : 32'h0;
            rsp_fault_q <= commit & fault;
        end
    end

    // Request latch and storage are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && commit && cur_we && !fault) begin
            mem_q[idx] <= merged;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_datamem_ctrl.sv
// tb/tb_datamem_ctrl.sv - self-checking bench for datamem_ctrl (0 and 3 wait states)

module tb_datamem_ctrl;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0 = 1'b0, v3 = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        rdy0, rv0, flt0, busy0;
    logic        rdy3, rv3, flt3, busy3;
    logic [31:0] rd0, rd3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    datamem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_fault(flt0), .busy(busy0)
    );

    datamem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3), .INIT_FILE("")) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_fault(flt3), .busy(busy3)
    );

    // Reference model: byte-addressed memory per DUT, big-endian by construction.
    logic [7:0] mem_m [longint unsigned];

    function automatic longint unsigned key(bit d, logic [31:0] a);
        return {31'b0, d, a};
    endfunction

    function automatic bit mdl_fault(logic [31:0] a, logic [1:0] sz);
        longint unsigned la = a;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        if (la < BASE || la >= longint'(BASE) + 4 * DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_load(bit d, logic [31:0] a, logic [1:0] sz, bit uns);
        logic [7:0]  b;
        logic [15:0] h;
        int          sv;
        case (sz)
            2'd0: begin
                b  = mem_m[key(d, a)];
                sv = $signed(b);
                return uns ? 32'(b) : 32'(sv);
            end
            2'd1: begin
                h  = {mem_m[key(d, a)], mem_m[key(d, a + 1)]};
                sv = $signed(h);
                return uns ? 32'(h) : 32'(sv);
            end
            default: return {mem_m[key(d, a)], mem_m[key(d, a + 1)],
                             mem_m[key(d, a + 2)], mem_m[key(d, a + 3)]};
        endcase
    endfunction

    task automatic mdl_store(bit d, logic [31:0] a, logic [1:0] sz, logic [31:0] wd);
        case (sz)
            2'd0: mem_m[key(d, a)] = wd[7:0];
            2'd1: begin
                mem_m[key(d, a)]     = wd[15:8];
                mem_m[key(d, a + 1)] = wd[7:0];
            end
            default: begin
                mem_m[key(d, a)]     = wd[31:24];
                mem_m[key(d, a + 1)] = wd[23:16];
                mem_m[key(d, a + 2)] = wd[15:8];
                mem_m[key(d, a + 3)] = wd[7:0];
            end
        endcase
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic f_rv(bit d);   return d ? rv3   : rv0;   endfunction
    function automatic logic f_rdy(bit d);  return d ? rdy3  : rdy0;  endfunction
    function automatic logic f_busy(bit d); return d ? busy3 : busy0; endfunction
    function automatic logic f_flt(bit d);  return d ? flt3  : flt0;  endfunction
    function automatic logic [31:0] f_rd(bit d); return d ? rd3 : rd0; endfunction

    // One complete access: handshake, latency, response fields, pulse width, model update.
    task automatic do_acc(string tag, bit d, bit we, logic [1:0] sz, bit uns,
                          logic [31:0] a, logic [31:0] wd, output logic [31:0] got);
        bit          ef;
        logic [31:0] er;
        int          lat;
        bit          found;
        int          ws;
        ws    = d ? 3 : 0;
        ef    = mdl_fault(a, sz);
        er    = (!we && !ef) ? mdl_load(d, a, sz, uns) : 32'h0;
        got   = '0;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        if (d) v3 = 1'b1; else v0 = 1'b1;
        chk({tag, ".ready"}, 32'(f_rdy(d)), 32'd1);
        @(posedge clk);
        #1;
        v0 = 1'b0; v3 = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat   = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (f_rv(d)) found = 1'b1;
            else begin
                lat++;
                chk({tag, ".wait_busy"}, 32'(f_busy(d)), 32'd1);
                chk({tag, ".wait_ready"}, 32'(f_rdy(d)), 32'd0);
            end
        end
        chk({tag, ".rsp_seen"}, 32'(found), 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'(ws));
        got = f_rd(d);
        chk({tag, ".rdata"}, got, er);
        chk({tag, ".fault"}, 32'(f_flt(d)), 32'(ef));
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(f_rv(d)), 32'd0);
        chk({tag, ".ready_after"}, 32'(f_rdy(d)), 32'd1);
        if (we && !ef) mdl_store(d, a, sz, wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [31:0] bad [5];
        int          cnt;
        bit          found;

        bad[0] = BASE - 1; bad[1] = BASE - 4; bad[2] = BASE + 4 * DEPTH;
        bad[3] = 32'hFFFF_FFFC; bad[4] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ready0", 32'(rdy0), 32'd0);
        chk("rst.ready3", 32'(rdy3), 32'd0);
        chk("rst.rv0", 32'(rv0), 32'd0);
        chk("rst.rd0", rd0, 32'h0);
        chk("rst.flt0", 32'(flt0), 32'd0);
        chk("rst.busy3", 32'(busy3), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ready_rel", 32'(rdy0), 32'd1);

        // 1: sw/lw with zero wait states
        do_acc("t1.sw", 0, 1, 2'd2, 0, 32'h0010_0004, 32'hDEAD_BEEF, got);
        do_acc("t1.lw", 0, 0, 2'd2, 0, 32'h0010_0004, 32'h0, got);
        chk("t1.lw_const", got, 32'hDEAD_BEEF);

        // 2: byte store into an existing word
        do_acc("t2.sw", 0, 1, 2'd2, 0, 32'h0010_0004, 32'h1122_3344, got);
        do_acc("t2.sb", 0, 1, 2'd0, 0, 32'h0010_0005, 32'h0000_0080, got);
        do_acc("t2.lw", 0, 0, 2'd2, 0, 32'h0010_0004, 32'h0, got);
        chk("t2.word_const", got, 32'h1180_3344);
        do_acc("t2.lb", 0, 0, 2'd0, 0, 32'h0010_0005, 32'h0, got);
        chk("t2.lb_const", got, 32'hFFFF_FF80);
        do_acc("t2.lbu", 0, 0, 2'd0, 1, 32'h0010_0005, 32'h0, got);
        chk("t2.lbu_const", got, 32'h0000_0080);

        // 3: half store
        do_acc("t3.sh", 0, 1, 2'd1, 0, 32'h0010_0006, 32'h0000_ABCD, got);
        do_acc("t3.lh", 0, 0, 2'd1, 0, 32'h0010_0006, 32'h0, got);
        chk("t3.lh_const", got, 32'hFFFF_ABCD);
        do_acc("t3.lhu", 0, 0, 2'd1, 1, 32'h0010_0006, 32'h0, got);
        chk("t3.lhu_const", got, 32'h0000_ABCD);
        do_acc("t3.lw", 0, 0, 2'd2, 0, 32'h0010_0004, 32'h0, got);
        chk("t3.word_const", got, 32'h1180_ABCD);

        // 4: faults leave memory untouched
        do_acc("t4.lw_mis", 0, 0, 2'd2, 0, 32'h0010_0002, 32'h0, got);
        do_acc("t4.lh_mis", 0, 0, 2'd1, 0, 32'h0010_0001, 32'h0, got);
        do_acc("t4.sw_low", 0, 1, 2'd2, 0, 32'h000F_FFFC, 32'h1234_5678, got);
        do_acc("t4.sz11", 0, 1, 2'd3, 0, 32'h0010_0004, 32'h5555_5555, got);
        do_acc("t4.sw_top", 0, 1, 2'd2, 0, BASE + 4 * DEPTH, 32'h7777_7777, got);
        do_acc("t4.reread", 0, 0, 2'd2, 0, 32'h0010_0004, 32'h0, got);
        chk("t4.unchanged_const", got, 32'h1180_ABCD);

        // Fill the checked window of both memories so every model byte is known.
        for (int w = 0; w < 16; w++) begin
            do_acc("fill0", 0, 1, 2'd2, 0, BASE + 32'(4 * w), $urandom, got);
            do_acc("fill3", 1, 1, 2'd2, 0, BASE + 32'(4 * w), $urandom, got);
        end
        do_acc("fill0.top", 0, 1, 2'd2, 0, BASE + 4 * DEPTH - 4, $urandom, got);
        do_acc("fill3.top", 1, 1, 2'd2, 0, BASE + 4 * DEPTH - 4, $urandom, got);

        // 5: wait states, busy/ready and back-to-back requests
        do_acc("t5.lw", 1, 0, 2'd2, 0, BASE + 4, 32'h0, got);
        begin
            logic [31:0] ea, eb;
            int          gap;
            ea = mdl_load(1, BASE + 4, 2'd2, 0);
            eb = mdl_load(1, BASE + 8, 2'd2, 0);
            @(negedge clk);
            req_we = 0; req_size = 2'd2; req_unsigned = 0; req_addr = BASE + 4;
            v3 = 1'b1;
            @(posedge clk);
            #1;
            req_addr = BASE + 8;
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                if (rv3) found = 1'b1;
                else chk("t5.b2b_ready_low", 32'(rdy3), 32'd0);
            end
            chk("t5.b2b_a_seen", 32'(found), 32'd1);
            chk("t5.b2b_a_rdata", rd3, ea);
            chk("t5.b2b_resp_ready", 32'(rdy3), 32'd0);
            found = 1'b0;
            gap   = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                gap++;
                if (rv3) found = 1'b1;
            end
            v3 = 1'b0;
            chk("t5.b2b_b_seen", 32'(found), 32'd1);
            chk("t5.b2b_gap", 32'(gap), 32'd5);
            chk("t5.b2b_b_rdata", rd3, eb);
            @(negedge clk);
        end

        // 6: reset during the wait of a store abandons it
        @(negedge clk);
        req_we = 1; req_size = 2'd2; req_addr = BASE + 8; req_wdata = 32'h5A5A_5A5A;
        v3 = 1'b1;
        @(posedge clk);
        #1;
        v3 = 1'b0;
        @(negedge clk);
        chk("t6.busy_pre", 32'(busy3), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6.ready_in_rst", 32'(rdy3), 32'd0);
        chk("t6.busy_in_rst", 32'(busy3), 32'd0);
        chk("t6.rv_in_rst", 32'(rv3), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6.ready_after_rst", 32'(rdy3), 32'd1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rv3) cnt++;
        end
        chk("t6.no_rsp", 32'(cnt), 32'd0);
        do_acc("t6.reread", 1, 0, 2'd2, 0, BASE + 8, 32'h0, got);

        // Randomized accesses against the byte model
        for (int n = 0; n < 120; n++) begin
            bit          d, we, uns;
            logic [1:0]  sz;
            d   = (n % 4 == 3);
            we  = 1'($urandom);
            uns = 1'($urandom);
            sz  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = bad[$urandom_range(0, 4)];
            else if ($urandom_range(0, 9) == 0) a = BASE + 4 * DEPTH - 4 + 32'($urandom_range(0, 3));
            else a = BASE + 32'($urandom_range(0, 63));
            do_acc($sformatf("rnd%0d", n), d, we, sz, uns, a, $urandom, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
